i2c_target: RTL and testbench
=============================

# i2c_target

I2C target (slave) that answers a single 7-bit address on the bus driven by the team's I2C controller. It oversamples SCL/SDA on the system clock, detects START/STOP, and shifts address and data bits. Written bytes go to the fabric as one-cycle valid pulses; bytes for reads are requested from the fabric one byte at a time. The block does not stretch the clock. It sits beside the controller in the bench as the bus responder, and in designs that expose a register port over I2C.

## Interface
- `ADDR`, default `7'h42`: own 7-bit target address.
- `clk_i`, in, 1: system clock; must be at least 16x the SCL frequency.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `scl_i`, in, 1: SCL line level (pulled up externally).
- `sda_i`, in, 1: SDA line level.
- `sda_oe_o`, out, 1: 1 pulls SDA low; 0 releases SDA (open-drain).
- `rx_data_o`, out, 8: last byte written by the controller.
- `rx_valid_o`, out, 1: one-cycle pulse; `rx_data_o` is valid on this cycle.
- `tx_req_o`, out, 1: one-cycle pulse; `tx_data_i` is sampled on this same cycle.
- `tx_data_i`, in, 8: byte to return on a read.
- `start_o`, out, 1: one-cycle pulse on START or repeated START.
- `stop_o`, out, 1: one-cycle pulse on STOP.
- `busy_o`, out, 1: high from START until STOP.

## Operation
- **Input synchronizers.** Each of `scl_i` and `sda_i` passes through a 2-FF synchronizer, then one history flop. Edge and level decisions use only the synchronized values.
- **START detect.** SDA falls while SCL is high. STOP detect: SDA rises while SCL is high. Both take priority over every FSM state.
  - START: go to ADDR, clear the bit counter, pulse `start_o`, set `busy_o`, release SDA.
  - STOP: go to IDLE, pulse `stop_o`, clear `busy_o`, release SDA.
- **Bit sampling.** Sample on the SCL rising edge, MSB first. Change SDA only on the SCL falling edge.
- **FSM states:**
  - IDLE: waits for START.
  - ADDR: shift 8 bits (7 address bits plus R/W). After the 8th rise, if `addr[7:1] == ADDR`, drive ACK on the next SCL fall and go to ADDR_ACK. Otherwise go to IGNORE.
  - ADDR_ACK: SDA is held low through one SCL high phase. On the following SCL fall:
    - Write (R/W=0): release SDA, go to WR_DATA.
    - Read (R/W=1): pulse `tx_req_o`, load the shift register from `tx_data_i`, drive bit 7, go to RD_DATA.
  - WR_DATA: shift 8 bits. After the 8th rise, pulse `rx_valid_o` with the byte. On the next SCL fall drive ACK and go to WR_ACK.
  - WR_ACK: on SCL fall, release SDA and go back to WR_DATA.
  - RD_DATA: on each SCL fall, drive the next bit; a `0` bit gives oe=1, a `1` bit gives oe=0. After the 8th bit's fall, release SDA and go to RD_ACK.
  - RD_ACK: sample SDA on the SCL rise.
    - 0 (controller ACK): on the next fall, pulse `tx_req_o`, load the next byte and drive its bit 7, go to RD_DATA.
    - 1 (NACK): go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- **Unbounded writes.** The target ACKs every write byte. There is no byte-count limit and the bit counter wraps each byte.
- **Fabric contract.** `tx_data_i` must be valid whenever `tx_req_o` pulses. There is no backpressure on `rx_valid_o`.

## Timing
- **Reset values.** All outputs are 0. FSM is in IDLE. Synchronizer flops reset to 1 (idle bus).
- **Input latency.** 2 cycles of synchronizer plus 1 cycle for the edge compare.
- **Output latency.** `sda_oe_o` changes 1 cycle after the detected SCL fall, about 4 `clk_i` cycles after the pin edge. This is well inside SCL low at a ratio of 16x or more.
- **`rx_valid_o` timing.** Pulses exactly 1 cycle after the detected 8th SCL rise of a write byte, before the ACK is driven.
- **`tx_req_o` timing.** Coincides with the SCL fall that begins each read byte. The byte's MSB is on `sda_oe_o` on the next cycle.
- **Simultaneous events.** START/STOP and an SCL edge cannot occur on the same cycle (SCL is high for both). If they did, START/STOP wins.
- **Reset mid-transfer.** SDA is released within the reset assertion, because the reset is asynchronous. No pulses are emitted and the FSM returns to IDLE.
- **STOP mid-byte.** The partial byte is discarded with no `rx_valid_o`.
- **Repeated START mid-read.** SDA is released immediately and the FSM enters ADDR.

## Structure
- `i2c_pkg` holds:
  - the state enum `i2c_tgt_state_e`: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE;
  - constants `I2C_ACK = 1'b0` and `I2C_NACK = 1'b1`.
- One sub-module, `i2c_sync_edge`, instantiated per line:
  - 2-FF synchronizer plus history flop;
  - outputs: level, rise pulse, fall pulse.
- Bench hookup: `sda_oe_o` drives the bus wire low through a `0`/`z` assign, alongside the pull-up.

## Test plan
- **Write.** START, 0x84, 0xA5, 0x00, STOP (ADDR=0x42).
  - ACK is low on all three ACK slots.
  - `rx_valid_o` pulses twice, with 0xA5 then 0x00.
  - `start_o` and `stop_o` each pulse once.
- **Read.** START, 0x85, `tx_data_i`=0x3C then 0xF0, controller ACKs then NACKs, STOP.
  - SDA carries 00111100 then 11110000.
  - `tx_req_o` pulses twice.
  - SDA is released after the NACK.
- **Wrong address.** START, 0x90, 0x55, STOP.
  - SDA is never pulled low.
  - No `rx_valid_o` or `tx_req_o` pulse.
  - `busy_o` is high until STOP.
- **Repeated START.** START, 0x84, 0x11, repeated START, 0x85 (read 0x77), NACK, STOP.
  - `rx_valid_o` carries 0x11.
  - `start_o` pulses twice.
  - Read returns 0x77.
- **Reset mid-read.** Assert `rst_ni` while the target is driving a 0 bit.
  - `sda_oe_o` goes to 0 asynchronously.
  - After release, a fresh write of 0x84/0x5A works.
- **STOP mid-byte.** STOP after 4 data bits.
  - No `rx_valid_o`.
  - FSM is in IDLE and `busy_o` is 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
// FSM state encoding and bus acknowledge levels.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_tgt_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer plus history flop for one I2C line.
// Resets to 1 so an idle (pulled-up) bus shows no edges.
module i2c_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign level_o = sync2_q;
  assign rise_o  = sync2_q & ~hist_q;
  assign fall_o  = ~sync2_q & hist_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target answering one 7-bit address; no clock stretching.
// Write bytes pulse rx_valid_o, read bytes are fetched via tx_req_o.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR = 7'h42
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       tx_req_o,
  input  logic [7:0] tx_data_i,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy_o
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge u_scl (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (scl_i),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_sync_edge u_sda (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (sda_i),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  i2c_tgt_state_e state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic       rw_q, rw_d;
  logic       oe_q, oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       busy_q, busy_d;
  logic       load;

  logic       start_det, stop_det;
  logic [7:0] byte_in;
  logic       last_bit;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign byte_in   = {shift_q[6:0], sda_lvl};
  assign last_bit  = (cnt_q == 3'd7);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    rw_d       = rw_q;
    oe_d       = oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    busy_d     = busy_q;
    load       = 1'b0;
    if (start_det) begin
      state_d = i2c_pkg::ADDR;
      cnt_d   = 3'd0;
      done_d  = 1'b0;
      oe_d    = 1'b0;
      start_d = 1'b1;
      busy_d  = 1'b1;
    end else if (stop_det) begin
      state_d = IDLE;
      done_d  = 1'b0;
      oe_d    = 1'b0;
      stop_d  = 1'b1;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        i2c_pkg::ADDR: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (last_bit) begin
              rw_d = sda_lvl;
              if (shift_q[6:0] == ADDR) done_d = 1'b1;
              else state_d = IGNORE;
            end
          end else if (scl_fall && done_q) begin
            done_d  = 1'b0;
            oe_d    = 1'b1;
            state_d = ADDR_ACK;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!rw_q) begin
              oe_d    = 1'b0;
              state_d = WR_DATA;
            end else begin
              load = 1'b1;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (last_bit) begin
              rx_valid_d = 1'b1;
              rx_data_d  = byte_in;
              done_d     = 1'b1;
            end
          end else if (scl_fall && done_q) begin
            done_d  = 1'b0;
            oe_d    = 1'b1;
            state_d = WR_ACK;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            state_d = WR_DATA;
          end
        end
        RD_DATA: begin
          // cnt_q counts bits already driven; wrap to 0 means all 8 are out
          if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              oe_d    = 1'b0;
              state_d = RD_ACK;
            end else begin
              oe_d    = ~shift_q[7];
              shift_d = {shift_q[6:0], 1'b0};
              cnt_d   = cnt_q + 3'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise && sda_lvl == I2C_NACK) state_d = IGNORE;
          else if (scl_fall) load = 1'b1;
        end
        default: ;
      endcase
    end
    if (load) begin
      oe_d    = ~tx_data_i[7];
      shift_d = {tx_data_i[6:0], 1'b0};
      cnt_d   = 3'd1;
      state_d = RD_DATA;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      shift_q    <= 8'h00;
      cnt_q      <= 3'd0;
      done_q     <= 1'b0;
      rw_q       <= 1'b0;
      oe_q       <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      rw_q       <= rw_d;
      oe_q       <= oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      busy_q     <= busy_d;
    end
  end

  assign sda_oe_o   = oe_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign tx_req_o   = load;
  assign start_o    = start_q;
  assign stop_o     = stop_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged controller on a
// wired-AND SDA line, pulse monitors and hand-computed bytes.
module tb_i2c_target;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_w;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       start_p;
  logic       stop_p;
  logic       busy;

  // open-drain bus with pull-up: low if either side pulls
  assign sda_w = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target #(.ADDR(7'h42)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .scl_i     (scl),
    .sda_i     (sda_w),
    .sda_oe_o  (sda_oe),
    .rx_data_o (rx_data),
    .rx_valid_o(rx_valid),
    .tx_req_o  (tx_req),
    .tx_data_i (tx_data),
    .start_o   (start_p),
    .stop_o    (stop_p),
    .busy_o    (busy)
  );

  logic [7:0] tx_tbl [0:7];
  logic [2:0] tx_idx = 3'd0;
  assign tx_data = tx_tbl[tx_idx];

  always @(posedge clk) if (tx_req) tx_idx <= tx_idx + 3'd1;

  int rx_cnt = 0, tx_cnt = 0, st_cnt = 0, sp_cnt = 0, oe_cnt = 0;
  int rx_bad = 0;
  logic [7:0] rx_log [$];

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt <= rx_cnt + 1;
      rx_log.push_back(rx_data);
      if (!scl || sda_oe) rx_bad <= rx_bad + 1;
    end
    if (tx_req) tx_cnt <= tx_cnt + 1;
    if (start_p) st_cnt <= st_cnt + 1;
    if (stop_p) sp_cnt <= sp_cnt + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    m_sda = 1'b0; tick(Q);
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(Q); m_sda = 1'b0;
    tick(Q); scl = 1'b1;
    tick(Q); m_sda = 1'b1;
    tick(Q);
  endtask

  task automatic send_bit(input logic b, output logic obs);
    tick(Q); m_sda = b;
    tick(Q); scl = 1'b1;
    tick(Q); obs = sda_w;
    tick(Q); scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic o;
    for (int i = 7; i >= 0; i--) send_bit(d[i], o);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic o;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, o);
      d[i] = o;
    end
    send_bit(nack, o);
  endtask

  logic       ack;
  logic [7:0] rd;
  int         rx0, tx0, st0, sp0, oe0;

  task automatic snap();
    rx0 = rx_cnt; tx0 = tx_cnt; st0 = st_cnt;
    sp0 = sp_cnt; oe0 = oe_cnt;
  endtask

  initial begin
    tx_tbl[0] = 8'h3C; tx_tbl[1] = 8'hF0;
    tx_tbl[2] = 8'h77; tx_tbl[3] = 8'h00;
    tx_tbl[4] = 8'h00; tx_tbl[5] = 8'h00;
    tx_tbl[6] = 8'h00; tx_tbl[7] = 8'h00;
    tick(4);
    check("rst_oe", 32'(sda_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pulses", 32'({rx_valid, tx_req, start_p, stop_p}), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    @(negedge clk); rst_n = 1'b1;
    tick(4);

    // write 0xA5, 0x00
    snap();
    i2c_start();
    tick(2);
    check("wr_busy", 32'(busy), 1);
    write_byte(8'h84, ack); check("wr_ack_addr", 32'(ack), 0);
    write_byte(8'hA5, ack); check("wr_ack_d0", 32'(ack), 0);
    write_byte(8'h00, ack); check("wr_ack_d1", 32'(ack), 0);
    i2c_stop();
    tick(4);
    check("wr_rx_cnt", 32'(rx_cnt - rx0), 2);
    if (rx_log.size() >= rx0 + 2) begin
      check("wr_rx0", 32'(rx_log[rx0]), 32'h A5);
      check("wr_rx1", 32'(rx_log[rx0 + 1]), 32'h00);
    end else check("wr_rx_log", 32'(rx_log.size()), 32'(rx0 + 2));
    check("wr_start", 32'(st_cnt - st0), 1);
    check("wr_stop", 32'(sp_cnt - sp0), 1);
    check("wr_busy_end", 32'(busy), 0);

    // read 0x3C (ACK), 0xF0 (NACK)
    snap();
    i2c_start();
    write_byte(8'h85, ack); check("rd_ack_addr", 32'(ack), 0);
    read_byte(1'b0, rd); check("rd_b0", 32'(rd), 32'h3C);
    read_byte(1'b1, rd); check("rd_b1", 32'(rd), 32'hF0);
    tick(6);
    check("rd_release", 32'(sda_oe), 0);
    check("rd_ignore", 32'(dut.state_q), 32'(i2c_pkg::IGNORE));
    i2c_stop();
    tick(4);
    check("rd_tx_cnt", 32'(tx_cnt - tx0), 2);
    check("rd_rx_cnt", 32'(rx_cnt - rx0), 0);

    // wrong address
    snap();
    i2c_start();
    write_byte(8'h90, ack); check("wa_nack_addr", 32'(ack), 1);
    check("wa_busy0", 32'(busy), 1);
    write_byte(8'h55, ack); check("wa_nack_d", 32'(ack), 1);
    check("wa_busy1", 32'(busy), 1);
    i2c_stop();
    tick(4);
    check("wa_busy_end", 32'(busy), 0);
    check("wa_oe_seen", 32'(oe_cnt - oe0), 0);
    check("wa_rx_tx", 32'((rx_cnt - rx0) + (tx_cnt - tx0)), 0);

    // repeated START: write 0x11 then read 0x77
    snap();
    i2c_start();
    write_byte(8'h84, ack); check("rs_ack_a0", 32'(ack), 0);
    write_byte(8'h11, ack); check("rs_ack_d", 32'(ack), 0);
    i2c_start();
    write_byte(8'h85, ack); check("rs_ack_a1", 32'(ack), 0);
    read_byte(1'b1, rd); check("rs_rd", 32'(rd), 32'h77);
    i2c_stop();
    tick(4);
    check("rs_rx_cnt", 32'(rx_cnt - rx0), 1);
    if (rx_log.size() > rx0)
      check("rs_rx", 32'(rx_log[rx0]), 32'h11);
    check("rs_start", 32'(st_cnt - st0), 2);

    // reset while driving a 0 bit of 0x00
    i2c_start();
    write_byte(8'h85, ack); check("rr_ack", 32'(ack), 0);
    tick(6);
    check("rr_driving", 32'(sda_oe), 1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("rr_async_rel", 32'(sda_oe), 0);
    check("rr_state", 32'(dut.state_q), 32'(i2c_pkg::IDLE));
    tick(3);
    scl = 1'b1; m_sda = 1'b1;
    tick(Q);
    @(negedge clk); rst_n = 1'b1;
    tick(Q);
    snap();
    i2c_start();
    write_byte(8'h84, ack); check("rr_w_ack_a", 32'(ack), 0);
    write_byte(8'h5A, ack); check("rr_w_ack_d", 32'(ack), 0);
    i2c_stop();
    tick(4);
    check("rr_rx_cnt", 32'(rx_cnt - rx0), 1);
    if (rx_log.size() > rx0)
      check("rr_rx", 32'(rx_log[rx0]), 32'h5A);

    // STOP after 4 data bits
    snap();
    i2c_start();
    write_byte(8'h84, ack); check("sm_ack", 32'(ack), 0);
    send_bit(1'b1, ack);
    send_bit(1'b0, ack);
    send_bit(1'b1, ack);
    send_bit(1'b0, ack);
    i2c_stop();
    tick(4);
    check("sm_rx_cnt", 32'(rx_cnt - rx0), 0);
    check("sm_state", 32'(dut.state_q), 32'(i2c_pkg::IDLE));
    check("sm_busy", 32'(busy), 0);
    check("sm_stop", 32'(sp_cnt - sp0), 1);

    check("rx_valid_timing", 32'(rx_bad), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
